// File: rtl/adel_pkg.sv
// Shared types and constants for the adel instruction-memory loader.
package adel_pkg;

    typedef enum logic [1:0] {IDLE, LOAD_LO, LOAD_HI, RUN} ldr_state_t;

    localparam int INST_W = 16;
    localparam logic [INST_W-1:0] FETCH_FAULT_INST = 16'h0000;

endpackage

// File: rtl/adel_imem_loader_if.sv
// Byte-serial program load port: start/length command plus a valid/ready byte stream.
interface adel_imem_loader_if #(
    parameter int DEPTH = 256
) ();
    localparam int AW = $clog2(DEPTH);

    logic          ld_start;
    logic [AW:0]   ld_len;
    logic [7:0]    ld_data;
    logic          ld_valid;
    logic          ld_ready;

    modport master (output ld_start, ld_len, ld_data, ld_valid, input ld_ready);
    modport slave  (input ld_start, ld_len, ld_data, ld_valid, output ld_ready);
endinterface

// File: rtl/adel_imem_ram.sv
// Instruction word array: one synchronous write port, one asynchronous read port.
module adel_imem_ram
    import adel_pkg::*;
#(
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [INST_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [INST_W-1:0] rdata
);

    logic [INST_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto plain RAM; contents survive rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/adel_imem_loader.sv
// Program loader FSM in front of the instruction memory; holds the core in reset while loading.
module adel_imem_loader
    import adel_pkg::*;
#(
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          pc,
    output logic [INST_W-1:0]    inst,
    adel_imem_loader_if.slave    ld,
    output logic                 core_nrst,
    output logic                 busy,
    output logic                 done,
    output logic                 fault
);

    ldr_state_t        state;
    logic [AW:0]       cnt;
    logic [AW-1:0]     addr;
    logic [7:0]        lo;
    logic [AW:0]       len_clamped;
    logic              load_go;
    logic              pc_oob;
    logic              we;
    logic [INST_W-1:0] rd_data;

    assign len_clamped = (ld.ld_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : ld.ld_len;
    assign load_go     = ld.ld_start && (len_clamped != '0) && (state == IDLE || state == RUN);
    assign pc_oob      = {1'b0, pc} >= 17'(DEPTH);
    assign ld.ld_ready = (state == LOAD_LO) || (state == LOAD_HI);

    // A byte arriving in the same cycle as rst is dropped rather than written.
    assign we = (state == LOAD_HI) && ld.ld_valid && !rst;

    adel_imem_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (addr),
        .wdata ({ld.ld_data, lo}),
        .raddr (pc[AW-1:0]),
        .rdata (rd_data)
    );

    assign inst = pc_oob ? FETCH_FAULT_INST : rd_data;

    // NOTE: all state uses <= so every branch reads pre-edge values; later writes override earlier ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            core_nrst <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
            cnt       <= '0;
            addr      <= '0;
            lo        <= '0;
        end else begin
            done <= 1'b0;
            if (core_nrst && pc_oob) begin
                fault <= 1'b1;
            end

            if (load_go) begin
                state     <= LOAD_LO;
                addr      <= '0;
                cnt       <= len_clamped;
                core_nrst <= 1'b0;
                busy      <= 1'b1;
                fault     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        // Zero-length load releases the core straight away.
                        if (ld.ld_start) begin
                            state     <= RUN;
                            core_nrst <= 1'b1;
                            done      <= 1'b1;
                        end
                    end
                    LOAD_LO: begin
                        if (ld.ld_valid) begin
                            lo    <= ld.ld_data;
                            state <= LOAD_HI;
                        end
                    end
                    LOAD_HI: begin
                        if (ld.ld_valid) begin
                            addr <= addr + AW'(1);
                            cnt  <= cnt - (AW+1)'(1);
                            if (cnt == (AW+1)'(1)) begin
                                state     <= RUN;
                                core_nrst <= 1'b1;
                                done      <= 1'b1;
                                busy      <= 1'b0;
                            end else begin
                                state <= LOAD_LO;
                            end
                        end
                    end
                    RUN: begin
                        core_nrst <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
